// File: rtl/pool_2.sv
// 2x2 / stride-2 signed max pooling of the conv2 feature maps held in the shared
// result BRAM; every pooled pixel is written back to the pool2 region of that BRAM.
`timescale 1ns/1ps

module pool_2 #(
    parameter int POOL2_DEEP        = 50,
    parameter int POOL2_INPUT       = 8,
    parameter int POOL2_OUTPUT      = 4,
    parameter int CONV2_RESULT_BASE = 14400,
    parameter int POOL2_RESULT_BASE = 17600
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pool_2_en,
    input  logic signed [7:0] result_bram_douta,
    output logic              result_bram_ena,
    output logic              result_bram_wea,
    output logic [14:0]       result_bram_addra,
    output logic [7:0]        result_bram_dina,
    output logic              pool_2_finish
);

    localparam int ADDR_W  = 15;
    localparam int CH_W    = $clog2(POOL2_DEEP + 1);
    localparam int RC_W    = (POOL2_OUTPUT > 1) ? $clog2(POOL2_OUTPUT) : 1;
    localparam int MAP_IN  = POOL2_INPUT * POOL2_INPUT;
    localparam int MAP_OUT = POOL2_OUTPUT * POOL2_OUTPUT;

    typedef enum logic [5:0] {
        S_IDLE    = 6'b000001,
        S_CHECK   = 6'b000010,
        S_LOAD    = 6'b000100,
        S_COMPARE = 6'b001000,
        S_STORE   = 6'b010000,
        S_DONE    = 6'b100000
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [CH_W-1:0]    r_channel;
    logic [RC_W-1:0]    r_row;
    logic [RC_W-1:0]    r_column;
    logic [1:0]         r_count;
    logic [1:0]         r_circle;
    logic signed [7:0]  r_window [4];
    logic signed [7:0]  r_max;

    logic               r_ena;
    logic               r_wea;
    logic [ADDR_W-1:0]  r_addra;
    logic [7:0]         r_dina;
    logic               r_finish;

    logic               w_last_slot;
    logic               w_last_pixel;
    logic               w_all_done;
    logic               w_col_wrap;
    logic               w_row_wrap;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic [ADDR_W-1:0]  w_wr_addr;
    logic signed [7:0]  w_max_lo;
    logic signed [7:0]  w_max_hi;
    logic signed [7:0]  w_max;

    assign result_bram_ena   = r_ena;
    assign result_bram_wea   = r_wea;
    assign result_bram_addra = r_addra;
    assign result_bram_dina  = r_dina;
    assign pool_2_finish     = r_finish;

    assign w_last_slot  = (r_circle == 2'd3);
    assign w_last_pixel = (r_count == 2'd3);
    assign w_all_done   = (r_channel == CH_W'(POOL2_DEEP));
    assign w_col_wrap   = (r_column == RC_W'(POOL2_OUTPUT - 1));
    assign w_row_wrap   = (r_row == RC_W'(POOL2_OUTPUT - 1));

    // r_count walks the window as {dr, dc}: (0,0), (0,1), (1,0), (1,1).
    assign w_rd_addr = ADDR_W'(CONV2_RESULT_BASE
                               + int'(r_channel) * MAP_IN
                               + (2 * int'(r_row) + int'(r_count[1])) * POOL2_INPUT
                               + 2 * int'(r_column) + int'(r_count[0]));

    assign w_wr_addr = ADDR_W'(POOL2_RESULT_BASE
                               + int'(r_channel) * MAP_OUT
                               + int'(r_row) * POOL2_OUTPUT
                               + int'(r_column));

    assign w_max_lo = (r_window[0] > r_window[1]) ? r_window[0] : r_window[1];
    assign w_max_hi = (r_window[2] > r_window[3]) ? r_window[2] : r_window[3];
    assign w_max    = (w_max_lo > w_max_hi) ? w_max_lo : w_max_hi;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // DONE is the only state that moves with the enable low: it returns to IDLE.
    always_comb begin
        // NOTE: default assigned first so every path drives w_state_next and no latch is inferred.
        w_state_next = r_state;
        if (pool_2_en) begin
            case (r_state)
                S_IDLE:    w_state_next = S_CHECK;
                S_CHECK:   w_state_next = w_all_done ? S_DONE : S_LOAD;
                S_LOAD:    w_state_next = (w_last_slot && w_last_pixel) ? S_COMPARE : S_LOAD;
                S_COMPARE: w_state_next = S_STORE;
                S_STORE:   w_state_next = w_last_slot ? S_CHECK : S_STORE;
                S_DONE:    w_state_next = S_DONE;
                default:   w_state_next = S_IDLE;
            endcase
        end else if (r_state == S_DONE) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_channel <= '0;
            r_row     <= '0;
            r_column  <= '0;
            r_count   <= '0;
            r_circle  <= '0;
            // NOTE: the window is only four bytes, so it is reset like any other register.
            for (int i = 0; i < 4; i++) begin
                r_window[i] <= '0;
            end
            r_max    <= '0;
            r_ena    <= 1'b0;
            r_wea    <= 1'b0;
            r_addra  <= '0;
            r_dina   <= '0;
            r_finish <= 1'b0;
        end else if (pool_2_en) begin
            // NOTE: non-blocking throughout, so every branch reads the pre-edge register values.
            case (r_state)
                S_IDLE: begin
                    r_channel <= '0;
                    r_row     <= '0;
                    r_column  <= '0;
                    r_count   <= '0;
                    r_circle  <= '0;
                    for (int i = 0; i < 4; i++) begin
                        r_window[i] <= '0;
                    end
                    r_ena    <= 1'b0;
                    r_wea    <= 1'b0;
                    r_finish <= 1'b0;
                end

                S_CHECK: begin
                    if (w_all_done) begin
                        r_finish <= 1'b1;
                    end else begin
                        r_count  <= '0;
                        r_circle <= '0;
                    end
                end

                // Each pixel owns a 4-cycle slot: address in cycle 0, data captured in cycle 3.
                S_LOAD: begin
                    case (r_circle)
                        2'd0: begin
                            r_ena    <= 1'b1;
                            r_wea    <= 1'b0;
                            r_addra  <= w_rd_addr;
                            r_circle <= 2'd1;
                        end
                        2'd1, 2'd2: begin
                            r_circle <= r_circle + 2'd1;
                        end
                        default: begin
                            r_window[r_count] <= result_bram_douta;
                            r_count           <= r_count + 2'd1;
                            r_circle          <= 2'd0;
                            if (w_last_pixel) begin
                                r_ena <= 1'b0;
                            end
                        end
                    endcase
                end

                S_COMPARE: begin
                    r_max    <= w_max;
                    r_circle <= 2'd0;
                end

                S_STORE: begin
                    case (r_circle)
                        2'd0: begin
                            r_ena    <= 1'b1;
                            r_wea    <= 1'b1;
                            r_addra  <= w_wr_addr;
                            r_dina   <= r_max;
                            r_circle <= 2'd1;
                        end
                        2'd1, 2'd2: begin
                            r_circle <= r_circle + 2'd1;
                        end
                        default: begin
                            r_ena    <= 1'b0;
                            r_wea    <= 1'b0;
                            r_circle <= 2'd0;
                            if (w_col_wrap) begin
                                r_column <= '0;
                                if (w_row_wrap) begin
                                    r_row     <= '0;
                                    r_channel <= r_channel + CH_W'(1);
                                end else begin
                                    r_row <= r_row + RC_W'(1);
                                end
                            end else begin
                                r_column <= r_column + RC_W'(1);
                            end
                        end
                    endcase
                end

                S_DONE: begin
                    r_finish <= 1'b1;
                    r_ena    <= 1'b0;
                    r_wea    <= 1'b0;
                end

                default: begin
                    r_ena <= 1'b0;
                    r_wea <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pool_2.sv
// Bench for pool_2: BRAM model with a write scoreboard, a table of single-window
// cases, and hand-written full-run, pause, reset and restart sequences.
`timescale 1ns/1ps

module tb_pool_2;

    localparam int DEEP        = 50;
    localparam int IN_W        = 8;
    localparam int OUT_W       = 4;
    localparam int CONV_BASE   = 14400;
    localparam int POOL_BASE   = 17600;
    localparam int N_OUT       = DEEP * OUT_W * OUT_W;
    localparam int RUN_CYCLES  = 17602;
    localparam logic [7:0] SENTINEL = 8'h99;

    logic        clk = 1'b0;
    logic        rst;
    logic        pool_2_en;
    logic [7:0]  douta;
    logic        ena;
    logic        wea;
    logic [14:0] addra;
    logic [7:0]  dina;
    logic        finish;

    always #5 clk = ~clk;

    pool_2 #(
        .POOL2_DEEP(DEEP),
        .POOL2_INPUT(IN_W),
        .POOL2_OUTPUT(OUT_W),
        .CONV2_RESULT_BASE(CONV_BASE),
        .POOL2_RESULT_BASE(POOL_BASE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pool_2_en(pool_2_en),
        .result_bram_douta(douta),
        .result_bram_ena(ena),
        .result_bram_wea(wea),
        .result_bram_addra(addra),
        .result_bram_dina(dina),
        .pool_2_finish(finish)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // BRAM model: the address seen in cycle t reaches douta two edges later, in time
    // for the DUT's capture at the end of its third slot cycle.
    logic [7:0] mem [0:32767];
    logic [7:0] p1 = '0;
    logic [7:0] p2 = '0;
    logic       init_req = 1'b0;
    logic       ovr_req  = 1'b0;
    logic [7:0] ovr_w [4];

    assign douta = p2;

    always @(posedge clk) begin
        if (init_req) begin
            for (int c = 0; c < DEEP; c++)
                for (int y = 0; y < IN_W; y++)
                    for (int x = 0; x < IN_W; x++)
                        mem[CONV_BASE + c*IN_W*IN_W + y*IN_W + x] <= 8'((c + y*IN_W + x) % 128);
            for (int i = 0; i < N_OUT; i++)
                mem[POOL_BASE + i] <= SENTINEL;
        end else if (ovr_req) begin
            mem[CONV_BASE]          <= ovr_w[0];
            mem[CONV_BASE + 1]      <= ovr_w[1];
            mem[CONV_BASE + IN_W]   <= ovr_w[2];
            mem[CONV_BASE + IN_W+1] <= ovr_w[3];
        end else if (ena && wea) begin
            mem[addra] <= dina;
        end
        if (ena) p1 <= mem[addra];
        p2 <= p1;
    end

    // Write scoreboard and bus monitor, sampled on the falling edge.
    typedef struct packed {
        logic [14:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         sb [$];
    logic [14:0] rd_log [$];
    logic        sb_on        = 1'b0;
    logic        ena_prev     = 1'b0;
    logic        wea_prev     = 1'b0;
    logic [14:0] addr_prev    = '0;
    int          wea_run      = 0;
    int          last_wea_len = 0;
    logic [14:0] last_wr_addr = '0;
    int          ena_cnt      = 0;

    always @(negedge clk) begin
        if (ena && !wea && (!ena_prev || wea_prev || addra != addr_prev))
            rd_log.push_back(addra);
        if (wea && !wea_prev) begin
            last_wr_addr <= addra;
            if (sb_on) begin
                if (sb.size() == 0) begin
                    check("unexpected_write_queue_len", 32'(sb.size()), 32'd1);
                end else begin
                    check("wr_addr", 32'(addra), 32'(sb[0].addr));
                    check("wr_data", 32'(dina), 32'(sb[0].data));
                    sb.pop_front();
                end
            end
        end
        if (wea) begin
            wea_run <= wea_run + 1;
        end else if (wea_prev) begin
            last_wea_len <= wea_run;
            wea_run      <= 0;
        end
        if (ena) ena_cnt <= ena_cnt + 1;
        ena_prev  <= ena;
        wea_prev  <= wea;
        addr_prev <= addra;
    end

    function automatic logic [7:0] exp_pool(input int c, input int r, input int k);
        return 8'((c + (2*r + 1)*IN_W + 2*k + 1) % 128);
    endfunction

    function automatic logic [31:0] log_at(input int i);
        return (rd_log.size() > i) ? 32'(rd_log[i]) : 32'hFFFF_FFFF;
    endfunction

    task automatic push_n(input int n);
        wr_t e;
        for (int o = 0; o < n; o++) begin
            e.addr = 15'(POOL_BASE + o);
            e.data = exp_pool(o / (OUT_W*OUT_W), (o / OUT_W) % OUT_W, o % OUT_W);
            sb.push_back(e);
        end
    endtask

    task automatic check_pool_mem(input string name);
        int bad = 0;
        for (int o = 0; o < N_OUT; o++)
            if (mem[POOL_BASE + o] !== exp_pool(o / (OUT_W*OUT_W), (o / OUT_W) % OUT_W, o % OUT_W))
                bad++;
        check(name, 32'(bad), 32'd0);
    endtask

    task automatic do_reset();
        pool_2_en = 1'b0;
        sb_on     = 1'b0;
        sb.delete();
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic do_init();
        init_req = 1'b1;
        @(posedge clk);
        #1 init_req = 1'b0;
    endtask

    task automatic do_ovr();
        ovr_req = 1'b1;
        @(posedge clk);
        #1 ovr_req = 1'b0;
    endtask

    typedef struct packed {
        logic [7:0] w0, w1, w2, w3;
        logic [7:0] exp;
    } win_vec_t;

    function automatic win_vec_t mk(input logic [7:0] a, b, c, d, e);
        win_vec_t v;
        v.w0 = a; v.w1 = b; v.w2 = c; v.w3 = d; v.exp = e;
        return v;
    endfunction

    win_vec_t vecs [9];

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          ena_base;
        int          frozen_bad;
        logic [25:0] snap;
        wr_t         e;

        rst = 1'b0;
        pool_2_en = 1'b0;
        for (int i = 0; i < 4; i++) ovr_w[i] = '0;

        vecs[0] = mk(8'hFB, 8'hFD, 8'h80, 8'hFF, 8'hFF);
        vecs[1] = mk(8'h80, 8'h80, 8'h80, 8'h80, 8'h80);
        vecs[2] = mk(8'h7F, 8'h00, 8'h00, 8'h00, 8'h7F);
        vecs[3] = mk(8'h00, 8'h00, 8'h00, 8'h7F, 8'h7F);
        vecs[4] = mk(8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFF);
        vecs[5] = mk(8'h01, 8'h02, 8'h03, 8'h04, 8'h04);
        vecs[6] = mk(8'h05, 8'hF9, 8'h05, 8'h02, 8'h05);
        vecs[7] = mk(8'h9C, 8'hCE, 8'h9D, 8'hCD, 8'hCE);
        vecs[8] = mk(8'h00, 8'h80, 8'hFF, 8'h01, 8'h01);

        repeat (3) @(posedge clk);
        #1;
        check("reset_ena",    32'(ena),    32'd0);
        check("reset_wea",    32'(wea),    32'd0);
        check("reset_addra",  32'(addra),  32'd0);
        check("reset_dina",   32'(dina),   32'd0);
        check("reset_finish", 32'(finish), 32'd0);
        rst = 1'b1;

        // Single-window table: the first pooled pixel of map 0.
        for (int v = 0; v < 9; v++) begin
            do_reset();
            do_init();
            ovr_w[0] = vecs[v].w0; ovr_w[1] = vecs[v].w1;
            ovr_w[2] = vecs[v].w2; ovr_w[3] = vecs[v].w3;
            do_ovr();
            e.addr = 15'(POOL_BASE);
            e.data = vecs[v].exp;
            sb.push_back(e);
            sb_on = 1'b1;
            pool_2_en = 1'b1;
            n = 0;
            while (sb.size() != 0 && n < 40) begin
                @(posedge clk);
                #1 n++;
            end
            check("win_write_seen_queue_len", 32'(sb.size()), 32'd0);
            repeat (2) @(posedge clk);
            #1 check("win_mem_value", 32'(mem[POOL_BASE]), 32'(vecs[v].exp));
            pool_2_en = 1'b0;
        end

        // Full uninterrupted run.
        do_reset();
        do_init();
        push_n(N_OUT);
        sb_on = 1'b1;
        rd_log.delete();
        pool_2_en = 1'b1;
        repeat (RUN_CYCLES - 1) @(posedge clk);
        #1 check("finish_before_17602", 32'(finish), 32'd0);
        @(posedge clk);
        #1 check("finish_at_17602", 32'(finish), 32'd1);
        check("run1_sb_drained", 32'(sb.size()), 32'd0);
        check("first_read_addr", log_at(0), 32'd14400);
        check("fourth_read_addr", log_at(3), 32'd14409);
        check("last_write_addr", 32'(last_wr_addr), 32'd18399);
        check("last_write_wea_cycles", 32'(last_wea_len), 32'd3);
        check_pool_mem("run1_pool_memory");

        ena_base = ena_cnt;
        repeat (100) @(posedge clk);
        #1 check("done_hold_accesses", 32'(ena_cnt - ena_base), 32'd0);
        check("done_hold_finish", 32'(finish), 32'd1);

        // Drop the enable for one edge (DONE -> IDLE), then run again.
        pool_2_en = 1'b0;
        do_init();
        check("idle_finish_kept", 32'(finish), 32'd1);
        push_n(N_OUT);
        rd_log.delete();
        pool_2_en = 1'b1;
        repeat (RUN_CYCLES - 1) @(posedge clk);
        #1 check("run2_finish_before", 32'(finish), 32'd0);
        @(posedge clk);
        #1 check("run2_finish_at_17602", 32'(finish), 32'd1);
        check("run2_sb_drained", 32'(sb.size()), 32'd0);
        check("run2_first_read_addr", log_at(0), 32'd14400);
        check_pool_mem("run2_pool_memory");

        // Pause for 10 cycles in LOAD circle 2 of output 100 (map 6, row 1, col 0).
        do_reset();
        do_init();
        push_n(N_OUT);
        sb_on = 1'b1;
        pool_2_en = 1'b1;
        repeat (2204) @(posedge clk);
        #1;
        check("pause_pre_ena", 32'(ena), 32'd1);
        check("pause_pre_wea", 32'(wea), 32'd0);
        check("pause_pre_addr", 32'(addra), 32'd14800);
        snap = {ena, wea, addra, dina, finish};
        pool_2_en = 1'b0;
        frozen_bad = 0;
        repeat (10) begin
            @(posedge clk);
            #1 if ({ena, wea, addra, dina, finish} !== snap) frozen_bad++;
        end
        check("pause_outputs_frozen_cycles_changed", 32'(frozen_bad), 32'd0);
        pool_2_en = 1'b1;
        n = 0;
        while (!finish && n < 20000) begin
            @(posedge clk);
            #1 n++;
        end
        check("pause_finish_cycle", 32'(2214 + n), 32'd17612);
        check("pause_sb_drained", 32'(sb.size()), 32'd0);
        check_pool_mem("pause_pool_memory");

        // Asynchronous reset in STORE circle 1 of channel 7 (output 112).
        do_reset();
        do_init();
        push_n(112);
        sb_on = 1'b1;
        pool_2_en = 1'b1;
        repeat (2484) @(posedge clk);
        #1;
        check("store_pre_ena", 32'(ena), 32'd1);
        check("store_pre_wea", 32'(wea), 32'd1);
        check("store_pre_addr", 32'(addra), 32'd17712);
        #2 rst = 1'b0;
        #1;
        check("async_rst_ena", 32'(ena), 32'd0);
        check("async_rst_wea", 32'(wea), 32'd0);
        check("async_rst_addra", 32'(addra), 32'd0);
        check("rst_test_sb_drained", 32'(sb.size()), 32'd0);
        sb_on = 1'b0;
        rd_log.delete();
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (rd_log.size() == 0 && n < 30) begin
            @(posedge clk);
            #1 n++;
        end
        check("restart_first_read_addr", log_at(0), 32'd14400);
        pool_2_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
